mips_multicycle: RTL and testbench
==================================

Name: mips_multicycle

Overview:
- Multicycle MIPS core: successor to the single-cycle core; executes one instruction over 3-5 states of an FSM controller.
- Uses one unified instruction/data memory port with a request/ready handshake, so memory may stall for any number of cycles.
- Adds reset-vector, register-count and stall parameters, an illegal-opcode trap and a retire pulse.
- Sits at the core level; an external memory model or cache drives mem_ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, number of architectural registers (power of two, 8..32); register index uses the low log2(NREGS) bits of rs/rt/rd; r0 is hard-wired to 0.
- TRAP_HALT, 1, 1 = core halts in TRAP state on an illegal opcode; 0 = illegal opcode is treated as a NOP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the core).
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled in the cycle mem_ready=1.
- mem_ready  in  1  completes the current request.
- pc  out  32  current PC register.
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
- trap  out  1  sticky; set on an illegal opcode when TRAP_HALT=1.

Behaviour:
- Reset (reset==0 at an edge):
  - pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, trap=0.
  - IR, A, B, ALUOut and MDR are cleared; the register file is not cleared.
  - Reset mid-transaction abandons the request: mem_req=0 from the next cycle.
- Supported instructions:
  - R-type add, sub, and, or, slt (funct 20/22/24/25/2A).
  - lw (23), sw (2B), beq (04), addi (08), j (02).
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready. On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: A<=reg[rs], B<=reg[rt], ALUOut<=pc+(signext(imm)<<2). Dispatch on opcode:
    - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - other -> TRAP if TRAP_HALT, else FETCH with a retire pulse.
  - MEMADR: ALUOut<=A+signext(imm); lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut. Hold until mem_ready; then MDR<=mem_rdata, go to MEMWB.
  - MEMWB: reg[rt]<=MDR, retire, go to FETCH.
  - MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. Hold until mem_ready; then retire, go to FETCH.
  - EXEC: ALUOut<=A op B, go to ALUWB.
  - ALUWB: reg[rd]<=ALUOut, retire, go to FETCH.
  - ADDIEX: ALUOut<=A+signext(imm), go to ADDIWB.
  - ADDIWB: reg[rt]<=ALUOut, retire, go to FETCH.
  - BRANCH: if A==B then pc<=ALUOut; retire, go to FETCH.
  - JUMP: pc<={pc[31:28], addr26, 2'b00}; retire, go to FETCH.
  - TRAP: trap=1, mem_req=0, stays in TRAP until reset.
  - An unknown R-type funct is an illegal opcode.
- Latency with zero wait states (mem_ready=1 in the first request cycle):
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
  - Each wait cycle on mem_ready adds one cycle.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - mem_req drops in the cycle after ready.
  - mem_ready while mem_req=0 is ignored.
- Arithmetic:
  - All 32-bit, wrap-around on overflow; no overflow exceptions.
  - slt is signed: result 1 or 0.
  - imm is sign-extended from bit 15.
- Writes to r0 are discarded; reads of r0 return 0.
- Register-file reads are asynchronous; writes occur on the clock edge.

Test Plan:
- Reset and fetch: hold reset=0 for 2 cycles with RESET_PC=32'h40 -> pc=0x40, mem_req=0; after release, mem_req=1 and mem_addr=0x40 in the first cycle.
- Wait states: addi r1,r0,5 with mem_ready held low for 3 cycles -> mem_addr stable for 4 cycles; r1=5; retire pulses in cycle 7.
- Load/store round trip: r2=0x1234, sw r2,8(r0), lw r3,8(r0) -> write request with addr=8, wdata=0x1234; then r3=0x1234; lw takes 5 cycles with zero waits.
- ALU operations: r1=-1, r2=1.
  - slt r4,r1,r2 -> r4=1.
  - sub r5,r2,r1 -> r5=2.
  - add r6,r1,r1 -> r6=0xFFFFFFFE.
  - add r0,r2,r2 -> r0 stays 0.
- Control flow:
  - beq taken at pc=0x10 with imm=-4 -> pc=0x04.
  - beq not taken -> pc=0x14.
  - j 0x100 -> pc=0x400; each takes 3 cycles.
- Trap and mid-operation reset:
  - Opcode 0x3F with TRAP_HALT=1 -> trap=1, mem_req=0 indefinitely.
  - Reset during a stalled MEMRD -> mem_req=0 next cycle, trap=0, pc=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core, FSM controller over one shared request/ready memory port
module mips_multicycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          NREGS     = 32,
    parameter bit          TRAP_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);
    localparam int RW = $clog2(NREGS);
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
    } state_t;

    state_t state, next;
    logic [31:0] ir, a, b, aluout, mdr;
    logic [31:0] regs [NREGS];
    logic [5:0] op, funct;
    logic [31:0] simm, rs_val, rt_val, alu_r, rf_wd;
    logic [RW-1:0] rs, rt, rd, rf_wa;
    logic r_ok, legal, rf_we;

    assign op     = ir[31:26];
    assign funct  = ir[5:0];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign rs     = ir[21 +: RW];
    assign rt     = ir[16 +: RW];
    assign rd     = ir[11 +: RW];
    assign rs_val = (rs == '0) ? 32'h0 : regs[rs];
    assign rt_val = (rt == '0) ? 32'h0 : regs[rt];
    assign r_ok   = (op == OP_R) && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 || funct == 6'h2A);
    assign legal  = r_ok || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
    assign alu_r  = (funct == 6'h22) ? a - b :
                    (funct == 6'h24) ? a & b :
                    (funct == 6'h25) ? a | b :
                    (funct == 6'h2A) ? {31'b0, $signed(a) < $signed(b)} : a + b;
    assign rf_we  = state == MEMWB || state == ALUWB || state == ADDIWB;
    assign rf_wa  = (state == ALUWB) ? rd : rt;
    assign rf_wd  = (state == MEMWB) ? mdr : aluout;
    assign trap   = state == TRAP;

    // Controller: next state plus memory-port and retire outputs; reset low silences the port at once
    always_comb begin
        next      = state;
        mem_req   = reset && (state == FETCH || state == MEMRD || state == MEMWR);
        mem_we    = state == MEMWR;
        mem_addr  = (state == FETCH) ? pc : aluout;
        mem_wdata = b;
        retire    = 1'b0;
        case (state)
            FETCH:  next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                next   = (op == OP_LW || op == OP_SW) ? MEMADR :
                         r_ok                         ? EXEC   :
                         (op == OP_BEQ)               ? BRANCH :
                         (op == OP_ADDI)              ? ADDIEX :
                         (op == OP_J)                 ? JUMP   :
                         TRAP_HALT                    ? TRAP   : FETCH;
                retire = reset && !legal && !TRAP_HALT;
            end
            MEMADR: next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next = mem_ready ? MEMWB : MEMRD;
            MEMWR:  begin
                next   = mem_ready ? FETCH : MEMWR;
                retire = reset && mem_ready;
            end
            EXEC:   next = ALUWB;
            ADDIEX: next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
                next   = FETCH;
                retire = reset;
            end
            default: next = TRAP;
        endcase
    end

    // State register and datapath registers, updated per the current state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            state <= next;
            case (state)
                FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                DECODE: begin
                    a      <= rs_val;
                    b      <= rt_val;
                    aluout <= pc + (simm << 2);
                end
                MEMADR, ADDIEX: aluout <= a + simm;
                MEMRD:  if (mem_ready) mdr <= mem_rdata;
                EXEC:   aluout <= alu_r;
                BRANCH: if (a == b) pc <= aluout;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Register file write port; r0 is never written so its read mux always yields zero
    always_ff @(posedge clk) begin
        if (reset && rf_we && rf_wa != '0) regs[rf_wa] <= rf_wd;
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed program run against a wait-state memory model
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [31:0] mem [0:1023];
    logic [31:0] wr_addr, wr_data;
    int          waits, cnt, checks, errors;

    mips_multicycle #(.RESET_PC(32'h40), .NREGS(32), .TRAP_HALT(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic ld(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[11:2]] = word;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory model answers just after the edge, outputs are then sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req === 1'b1) begin
            if (cnt < waits) begin
                mem_ready = 1'b0;
                cnt++;
            end else begin
                mem_ready = 1'b1;
                cnt = 0;
                if (mem_we) begin
                    mem[mem_addr[11:2]] = mem_wdata;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end else mem_rdata = mem[mem_addr[11:2]];
            end
        end else begin
            mem_ready = 1'b0;
            cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [31:0] epc, input int ecyc);
        int n;
        tick();
        n = 1;
        chk({tag, " pc"}, pc, epc);
        while (retire !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " cycles"}, n, ecyc);
    endtask

    task automatic stchk(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, " waddr"}, wr_addr, addr);
        chk({tag, " wdata"}, wr_data, data);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; waits = 0; cnt = 0;
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ld(32'h40, it(6'h08, 0, 1, 16'd5));
        ld(32'h44, it(6'h2B, 0, 1, 16'h200));
        ld(32'h48, it(6'h08, 0, 2, 16'h1234));
        ld(32'h4C, it(6'h2B, 0, 2, 16'h8));
        ld(32'h50, it(6'h23, 0, 3, 16'h8));
        ld(32'h54, it(6'h2B, 0, 3, 16'h204));
        ld(32'h58, it(6'h08, 0, 1, 16'hFFFF));
        ld(32'h5C, it(6'h08, 0, 2, 16'd1));
        ld(32'h60, rr(1, 2, 4, 6'h2A));
        ld(32'h64, it(6'h2B, 0, 4, 16'h208));
        ld(32'h68, rr(2, 1, 5, 6'h22));
        ld(32'h6C, it(6'h2B, 0, 5, 16'h20C));
        ld(32'h70, rr(1, 1, 6, 6'h20));
        ld(32'h74, it(6'h2B, 0, 6, 16'h210));
        ld(32'h78, rr(2, 2, 0, 6'h20));
        ld(32'h7C, it(6'h2B, 0, 0, 16'h214));
        ld(32'h80, rr(1, 2, 7, 6'h24));
        ld(32'h84, it(6'h2B, 0, 7, 16'h218));
        ld(32'h88, rr(5, 2, 8, 6'h25));
        ld(32'h8C, it(6'h2B, 0, 8, 16'h21C));
        ld(32'h90, it(6'h08, 0, 10, 16'd0));
        ld(32'h94, {6'h02, 26'd4});
        ld(32'h10, it(6'h04, 10, 0, 16'hFFFC));
        ld(32'h04, {6'h02, 26'd3});
        ld(32'h0C, it(6'h08, 0, 10, 16'd1));
        ld(32'h14, {6'h02, 26'h100});
        ld(32'h400, 32'hFC00_0000);

        // Reset held for two edges, then released
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset pc", pc, 32'h40);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset retire", retire, 1'b0);
        chk("reset trap", trap, 1'b0);
        reset = 1'b1;
        #1;
        chk("first fetch req", mem_req, 1'b1);
        chk("first fetch addr", mem_addr, 32'h40);

        // addi r1,r0,5 with three wait states on the fetch
        waits = 3;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("stall addr", mem_addr, 32'h40);
            chk("stall req", mem_req, 1'b1);
            chk("stall ready", mem_ready, (i == 4) ? 1'b1 : 1'b0);
        end
        waits = 0;
        n = 4;
        while (retire !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("addi stalled cycles", n, 7);
        step("sw r1", 32'h44, 4);      stchk("r1", 32'h200, 32'd5);
        step("addi r2", 32'h48, 4);
        step("sw r2", 32'h4C, 4);      stchk("sw r2", 32'h8, 32'h1234);
        step("lw r3", 32'h50, 5);
        step("sw r3", 32'h54, 4);      stchk("r3", 32'h204, 32'h1234);
        step("addi r1", 32'h58, 4);
        step("addi r2b", 32'h5C, 4);
        step("slt", 32'h60, 4);
        step("sw r4", 32'h64, 4);      stchk("slt r4", 32'h208, 32'd1);
        step("sub", 32'h68, 4);
        step("sw r5", 32'h6C, 4);      stchk("sub r5", 32'h20C, 32'd2);
        step("add", 32'h70, 4);
        step("sw r6", 32'h74, 4);      stchk("add r6", 32'h210, 32'hFFFF_FFFE);
        step("add r0", 32'h78, 4);
        step("sw r0", 32'h7C, 4);      stchk("r0", 32'h214, 32'd0);
        step("and", 32'h80, 4);
        step("sw r7", 32'h84, 4);      stchk("and r7", 32'h218, 32'd1);
        step("or", 32'h88, 4);
        step("sw r8", 32'h8C, 4);      stchk("or r8", 32'h21C, 32'd3);
        step("addi r10", 32'h90, 4);
        step("j 4", 32'h94, 3);
        step("beq taken", 32'h10, 3);
        step("j 3", 32'h04, 3);
        step("addi r10b", 32'h0C, 4);
        step("beq not taken", 32'h10, 3);
        step("j 0x100", 32'h14, 3);

        // Illegal opcode traps and holds the port idle
        tick();
        chk("trap fetch addr", mem_addr, 32'h400);
        tick();
        tick();
        chk("trap set", trap, 1'b1);
        chk("trap req", mem_req, 1'b0);
        repeat (5) tick();
        chk("trap sticky", trap, 1'b1);
        chk("trap req idle", mem_req, 1'b0);
        chk("trap no retire", retire, 1'b0);
        chk("trap pc", pc, 32'h404);

        // Reset out of trap, then reset during a stalled load
        ld(32'h40, it(6'h23, 0, 3, 16'h8));
        reset = 1'b0;
        tick();
        chk("trap reset pc", pc, 32'h40);
        chk("trap reset trap", trap, 1'b0);
        chk("trap reset req", mem_req, 1'b0);
        reset = 1'b1;
        tick();
        chk("lw fetch addr", mem_addr, 32'h40);
        tick();
        tick();
        waits = 10;
        tick();
        chk("memrd req", mem_req, 1'b1);
        chk("memrd we", mem_we, 1'b0);
        chk("memrd addr", mem_addr, 32'h8);
        tick();
        chk("memrd hold addr", mem_addr, 32'h8);
        reset = 1'b0;
        tick();
        chk("midreset req", mem_req, 1'b0);
        chk("midreset trap", trap, 1'b0);
        chk("midreset pc", pc, 32'h40);
        reset = 1'b1;
        waits = 0;
        step("lw after reset", 32'h40, 5);
        step("sw after reset", 32'h44, 4);
        stchk("r1 after reset", 32'h200, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
